// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 core front end.
package cpu_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP,
    HOLD
  } fetch_state_t;

  // addi x0,x0,0 -- placed in IF/ID when empty or flushed.
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush wins over load, otherwise hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic        D_valid
);

  // Register update: reset, flush to NOP, load, or hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      D_pc    <= '0;
      D_inst  <= NOP_INST;
      D_valid <= 1'b0;
    end else if (flush) begin
      D_inst  <= NOP_INST;
      D_valid <= 1'b0;
    end else if (load) begin
      D_pc    <= pc_in;
      D_inst  <= inst_in;
      D_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake FSM, skid buffer,
// and the IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [31:0] next_pc,
  output logic [31:0] F_pc,
  output logic [31:0] F_pc_plus4,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic        D_valid
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  skid_buf;
  logic         buf_load;
  logic         d_load;
  logic         d_flush;
  logic [31:0]  d_data;
  logic         can_load;

  assign F_pc       = pc;
  assign F_pc_plus4 = pc + 32'd4;
  assign im_addr    = pc;
  assign im_req     = rst && (state == FETCH);
  assign can_load   = !stall || !D_valid;

  // Next state, IF/ID controls and PC selection; jb overrides everything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    d_load     = 1'b0;
    d_flush    = 1'b0;
    d_data     = im_rdata;
    buf_load   = 1'b0;
    case (state)
      FETCH: begin
        if (im_ready) state_next = jb ? DROP : WAIT;
      end
      WAIT: begin
        if (jb) begin
          state_next = im_rvalid ? FETCH : DROP;
        end else if (im_rvalid) begin
          if (can_load) begin
            d_load     = 1'b1;
            state_next = FETCH;
          end else begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (jb) begin
          state_next = FETCH;
        end else if (can_load) begin
          d_load     = 1'b1;
          d_data     = skid_buf;
          state_next = FETCH;
        end
      end
      DROP: begin
        if (im_rvalid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (jb) begin
      d_flush = 1'b1;
      d_load  = 1'b0;
      pc_next = next_pc;
    end else if (d_load) begin
      pc_next = next_pc;
    end
  end

  // State, PC and skid buffer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      skid_buf <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (buf_load) skid_buf <= im_rdata;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (d_load),
    .flush   (d_flush),
    .pc_in   (pc),
    .inst_in (d_data),
    .D_pc    (D_pc),
    .D_inst  (D_inst),
    .D_valid (D_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model plus memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jb;
  logic [31:0] next_pc;
  logic [31:0] F_pc;
  logic [31:0] F_pc_plus4;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] D_pc;
  logic [31:0] D_inst;
  logic        D_valid;

  int checks;
  int errors;

  // Memory: one outstanding access, response after lat cycles.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat;

  // Model: transaction bookkeeping of the fetch stage.
  logic [31:0] m_pc, m_dpc, m_dinst;
  logic        m_dvalid;
  logic        m_outst;   // request accepted, response not yet seen
  logic        m_disc;    // that response must be thrown away
  logic        m_bufd;    // a fetched instruction waits for decode
  logic [31:0] m_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .jb         (jb),
    .next_pc    (next_pc),
    .F_pc       (F_pc),
    .F_pc_plus4 (F_pc_plus4),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ready   (im_ready),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .D_pc       (D_pc),
    .D_inst     (D_inst),
    .D_valid    (D_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h13;
  endfunction

  assign im_rvalid = mem_busy && (mem_cnt == 0);
  assign im_rdata  = im_rvalid ? memf(mem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance model and memory by one clock using the inputs held over the edge.
  task automatic model_update();
    logic        rv, acc, canload;
    logic [31:0] rd;
    rv      = im_rvalid;
    rd      = im_rdata;
    acc     = !m_outst && !m_bufd && im_ready;
    canload = !stall || !m_dvalid;
    if (!rst) begin
      m_pc = 32'h0; m_dpc = 32'h0; m_dinst = NOP; m_dvalid = 1'b0;
      m_outst = 1'b0; m_disc = 1'b0; m_bufd = 1'b0;
      mem_busy = 1'b0; mem_cnt = 0;
      return;
    end
    if (acc) mem_addr = m_pc;
    if (jb) begin
      m_pc = next_pc; m_dvalid = 1'b0; m_dinst = NOP; m_bufd = 1'b0;
      if (m_outst) begin
        if (rv) m_outst = 1'b0;
        else    m_disc  = 1'b1;
      end
      if (acc) begin m_outst = 1'b1; m_disc = 1'b1; end
    end else begin
      if (m_outst && rv) begin
        m_outst = 1'b0;
        if (!m_disc) begin
          if (canload) begin
            m_dpc = m_pc; m_dinst = rd; m_dvalid = 1'b1; m_pc = next_pc;
          end else begin
            m_bufd = 1'b1; m_buf = rd;
          end
        end
        m_disc = 1'b0;
      end else if (m_bufd && canload) begin
        m_dpc = m_pc; m_dinst = m_buf; m_dvalid = 1'b1; m_pc = next_pc;
        m_bufd = 1'b0;
      end
      if (acc) begin m_outst = 1'b1; m_disc = 1'b0; end
    end
    if (rv) mem_busy = 1'b0;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = lat - 1;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
  endtask

  task automatic compare_model();
    chk("F_pc",       F_pc,       m_pc);
    chk("F_pc_plus4", F_pc_plus4, m_pc + 32'd4);
    chk("im_addr",    im_addr,    m_pc);
    chk("im_req",     {31'h0, im_req}, {31'h0, rst && !m_outst && !m_bufd});
    chk("D_valid",    {31'h0, D_valid}, {31'h0, m_dvalid});
    chk("D_inst",     D_inst,     m_dinst);
    if (m_dvalid) chk("D_pc", D_pc, m_dpc);
  endtask

  // One cycle: drive at negedge, model after the edge, compare at next negedge.
  task automatic step(input logic s, input logic j, input logic [31:0] t, input logic r);
    stall    = s;
    jb       = j;
    im_ready = r;
    next_pc  = j ? t : m_pc + 32'd4;
    @(posedge clk);
    #1;
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    logic [31:0] tv;
    logic [31:0] t;
    logic        j;
    clk = 1'b0; rst = 1'b0; stall = 1'b0; jb = 1'b0; im_ready = 1'b0;
    next_pc = 32'h0; lat = 1; checks = 0; errors = 0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
    m_pc = 32'h0; m_dpc = 32'h0; m_dinst = NOP; m_dvalid = 1'b0;
    m_outst = 1'b0; m_disc = 1'b0; m_bufd = 1'b0; m_buf = 32'h0;
    @(negedge clk);

    // Reset
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_D_valid", {31'h0, D_valid}, 32'h0);
    chk("rst_D_inst",  D_inst, 32'h0000_0013);
    chk("rst_im_req",  {31'h0, im_req}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_im_req", {31'h0, im_req}, 32'h1);
    chk("rel_addr0",  im_addr, 32'h0);

    // Straight-line fetch, best case
    lat = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wait_no_req", {31'h0, im_req}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("first_D_valid", {31'h0, D_valid}, 32'h1);
    chk("first_D_pc",    D_pc,   32'h0);
    chk("first_D_inst",  D_inst, 32'h00A0_0093);
    chk("addr4",         im_addr, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("second_D_pc", D_pc, 32'h4);

    // Stall into HOLD
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_D_pc",   D_pc, 32'h4);
    chk("hold_no_req", {31'h0, im_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold2_D_pc", D_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unhold_D_pc",   D_pc, 32'h8);
    chk("unhold_D_inst", D_inst, memf(32'h8));
    chk("addr12",        im_addr, 32'hC);

    // Redirect in WAIT, late response dropped
    lat = 2;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    chk("jb_D_valid", {31'h0, D_valid}, 32'h0);
    chk("jb_F_pc",    F_pc, 32'h100);
    chk("drop_no_req", {31'h0, im_req}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drop_D_valid", {31'h0, D_valid}, 32'h0);
    chk("addr100",      im_addr, 32'h100);
    chk("drop_req",     {31'h0, im_req}, 32'h1);

    // Simultaneous rvalid and jb
    lat = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    chk("sim_D_valid", {31'h0, D_valid}, 32'h0);
    chk("sim_D_inst",  D_inst, 32'h0000_0013);
    chk("addr200",     im_addr, 32'h200);
    chk("sim_req",     {31'h0, im_req}, 32'h1);

    // Slow memory, then wrap-around
    repeat (3) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("slow_req",  {31'h0, im_req}, 32'h1);
      chk("slow_addr", im_addr, 32'h200);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("slow_D_pc", D_pc, 32'h200);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("addr_top",  im_addr, 32'hFFFF_FFFC);
    chk("plus4_wrap", F_pc_plus4, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_D_pc", D_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", im_addr, 32'h0);

    // Randomized traffic
    for (int unsigned i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      lat = $urandom_range(1, 4);
      j   = ($urandom_range(0, 9) == 0);
      tv  = $urandom_range(0, 1023);
      t   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (tv << 2);
      step($urandom_range(0, 2) == 0, j, t, $urandom_range(0, 4) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
